// File: rtl/irq_ctrl_if.sv
// Register-window bus between the system bridge and irq_ctrl.
// master = bridge side, slave = irq_ctrl side.
interface irq_ctrl_if;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output we, addr, wdata, input rdata);
    modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source pending/mask/edge-level mode feeding a registered CP0 hw_int[5:0].
// Optional macro IRQ_SYNC_EN adds a 2-flop synchronizer on dev_irq.
module irq_ctrl #(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] dev_irq,
    irq_ctrl_if.slave       bus,
    output logic [5:0]      hw_int
);

    logic [NSRC-1:0] s;
    logic [NSRC-1:0] prev_reg;
    logic [NSRC-1:0] pend_reg;
    logic [NSRC-1:0] pend_next;
    logic [NSRC-1:0] mask_reg;
    logic [NSRC-1:0] mode_reg;
    logic [NSRC-1:0] pend_masked;
    logic [NSRC-1:0] mode_chg;
    logic [NSRC-1:0] w1c;
    logic [5:0]      hw_int_reg;
    logic [5:0]      hw_int_next;
    logic            wr_pend;
    logic            wr_mask;
    logic            wr_mode;
    logic [2:0]      top_idx;
    logic            top_any;
    logic [31:0]     rdata_next;
    logic            unused_wdata;

`ifdef IRQ_SYNC_EN
    logic [NSRC-1:0] sync1_reg;
    logic [NSRC-1:0] sync2_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= dev_irq;
            sync2_reg <= sync1_reg;
        end
    end

    assign s = sync2_reg;
`else
    assign s = dev_irq;
`endif

    assign wr_pend = bus.we && (bus.addr == 2'd0);
    assign wr_mask = bus.we && (bus.addr == 2'd1);
    assign wr_mode = bus.we && (bus.addr == 2'd2);

    assign mode_chg     = {NSRC{wr_mode}} & (bus.wdata[NSRC-1:0] ^ mode_reg);
    assign w1c          = {NSRC{wr_pend}} & bus.wdata[NSRC-1:0];
    assign pend_masked  = pend_reg & mask_reg;
    assign unused_wdata = ^bus.wdata[31:NSRC];

    // Priority per bit: mode change clears, level follows input, edge set beats W1C.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
            assign pend_next[gi] = mode_chg[gi]                  ? 1'b0 :
                                   !mode_reg[gi]                 ? s[gi] :
                                   (s[gi] && !prev_reg[gi])      ? 1'b1 :
                                   w1c[gi]                       ? 1'b0 :
                                                                   pend_reg[gi];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_hw
            if (gi < NSRC) begin : g_src
                assign hw_int_next[gi] = pend_masked[gi];
            end else begin : g_tie
                assign hw_int_next[gi] = 1'b0;
            end
        end
    endgenerate

    // Scan from the top down so the lowest set index is the one left standing.
    always_comb begin
        top_idx = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend_masked[i]) begin
                top_idx = 3'(i);
            end
        end
    end

    assign top_any = |pend_masked;

    always_comb begin
        rdata_next = '0;
        case (bus.addr)
            2'd0: rdata_next[NSRC-1:0] = pend_reg;
            2'd1: rdata_next[NSRC-1:0] = mask_reg;
            2'd2: rdata_next[NSRC-1:0] = mode_reg;
            default: begin
                rdata_next[31]  = top_any;
                rdata_next[2:0] = top_idx;
            end
        endcase
    end

    assign bus.rdata = rdata_next;
    assign hw_int    = hw_int_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg   <= '0;
            pend_reg   <= '0;
            mask_reg   <= '0;
            mode_reg   <= '0;
            hw_int_reg <= '0;
        end else begin
            prev_reg   <= s;
            pend_reg   <= pend_next;
            hw_int_reg <= hw_int_next;
            if (wr_mask) begin
                mask_reg <= bus.wdata[NSRC-1:0];
            end
            if (wr_mode) begin
                mode_reg <= bus.wdata[NSRC-1:0];
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl (sync disabled): expected values queued as stimulus is driven,
// popped and asserted when the DUT output is sampled.
module tb_irq_ctrl;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [5:0]  dev_irq;
    logic [5:0]  hw_int;
    irq_ctrl_if  bus ();

    exp_t        sb_q[$];
    int          checks;
    int          passed;

    irq_ctrl #(.NSRC(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .dev_irq (dev_irq),
        .bus     (bus),
        .hw_int  (hw_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish within 100000 time units");
        $fatal(1, "timeout");
    end

    // One active edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        tick();
        bus.we    = 1'b0;
        bus.wdata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag   = tag;
        e.value = v;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] observed);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard_empty: observed %h required a queued expectation", observed);
        end else begin
            e = sb_q.pop_front();
            assert (observed === e.value) begin
                passed++;
                $display("check %-12s observed %h expected %h ok", e.tag, observed, e.value);
            end else begin
                $error("FAIL %s: observed %h expected %h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] v);
        logic [31:0] d;
        expect_val(tag, v);
        rd(a, d);
        check(d);
    endtask

    task automatic check_hw(input string tag, input logic [5:0] v);
        expect_val(tag, {26'd0, v});
        check({26'd0, hw_int});
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        reset     = 1'b1;
        dev_irq   = '0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check_reg("rst_pend", 2'd0, 32'h0);
        check_reg("rst_mask", 2'd1, 32'h0);
        check_reg("rst_mode", 2'd2, 32'h0);
        check_reg("rst_top",  2'd3, 32'h0);
        check_hw ("rst_hw",   6'h00);

        // Level source 2: PEND at E0, hw_int at E1
        dev_irq = 6'h04;
        wr(2'd1, 32'h3F);
        check_reg("lvl_pend",  2'd0, 32'h04);
        check_hw ("lvl_hw_e0", 6'h00);
        tick();
        check_hw ("lvl_hw_e1", 6'h04);
        check_reg("lvl_top",   2'd3, 32'h8000_0002);

        // Edge source 0: single-cycle pulse latched, then W1C
        dev_irq = 6'h00;
        tick();
        wr(2'd2, 32'h01);
        wr(2'd1, 32'h01);
        dev_irq = 6'h01;
        tick();
        dev_irq = 6'h00;
        check_reg("edg_pend",  2'd0, 32'h01);
        tick();
        check_hw ("edg_hw",    6'h01);
        tick();
        check_hw ("edg_hold",  6'h01);
        wr(2'd0, 32'h01);
        check_reg("w1c_pend",  2'd0, 32'h00);
        check_hw ("w1c_hw_e0", 6'h01);
        tick();
        check_hw ("w1c_hw_e1", 6'h00);

        // Set beats W1C on the same edge
        dev_irq = 6'h01;
        wr(2'd0, 32'h01);
        check_reg("set_wins",  2'd0, 32'h01);
        dev_irq = 6'h00;

        // All sources level, masked off, then partial unmask
        wr(2'd2, 32'h00);
        check_reg("mchg_clr",  2'd0, 32'h00);
        wr(2'd1, 32'h00);
        dev_irq = 6'h3F;
        tick();
        tick();
        check_reg("msk_pend",  2'd0, 32'h3F);
        check_hw ("msk_hw",    6'h00);
        check_reg("msk_top",   2'd3, 32'h0);
        wr(2'd1, 32'h30);
        check_hw ("msk_hw_e0", 6'h00);
        tick();
        check_hw ("msk_hw_e1", 6'h30);
        check_reg("msk_top2",  2'd3, 32'h8000_0004);

        // W1C ignored on level sources
        wr(2'd0, 32'h3F);
        check_reg("w1c_lvl",   2'd0, 32'h3F);

        // Edge source 1 pending, then mode change clears it that edge
        dev_irq = 6'h00;
        wr(2'd2, 32'h02);
        dev_irq = 6'h02;
        tick();
        check_reg("e1_pend",   2'd0, 32'h02);
        wr(2'd2, 32'h00);
        check_reg("e1_mclr",   2'd0, 32'h00);
        tick();
        check_reg("e1_resume", 2'd0, 32'h02);

        // Reset overrides a concurrent MASK write
        dev_irq = 6'h3F;
        wr(2'd1, 32'h3F);
        tick();
        check_hw ("pre_rst_hw", 6'h3F);
        reset     = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 2'd1;
        bus.wdata = 32'h3F;
        tick();
        reset     = 1'b0;
        bus.we    = 1'b0;
        check_reg("mrst_pend", 2'd0, 32'h0);
        check_reg("mrst_mask", 2'd1, 32'h0);
        check_reg("mrst_mode", 2'd2, 32'h0);
        check_reg("mrst_top",  2'd3, 32'h0);
        check_hw ("mrst_hw",   6'h00);

        if (sb_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_left: observed %0d entries required 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
